// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with x0 hardwired to zero, same-cycle
// write bypass, a per-register pending scoreboard and a post-reset clear sweep.
//
// state    | meaning
// ST_CLEAR | sweeping zeros into the array, writes/issues ignored, reads return 0
// ST_RUN   | normal operation, READY high
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    output logic                       READY,
    input  logic                       WE,
    input  logic [ADDR_W-1:0]          WADDR,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic                       ISSUE,
    input  logic [ADDR_W-1:0]          ISSUE_ADDR,
    input  logic [NUM_RD*ADDR_W-1:0]   RADDR,
    output logic [NUM_RD*DATA_W-1:0]   RDATA,
    output logic [NUM_RD-1:0]          RBUSY
);

    localparam int NREGS = 2**ADDR_W;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    logic              r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [NREGS-1:0]  r_pend;
    logic [DATA_W-1:0] r_mem [NREGS];

    logic              w_run;
    logic              w_wr;
    logic              w_iss;
    logic [NREGS-1:0]  w_pend_nxt;

    assign w_run = (r_state == ST_RUN);
    assign READY = w_run;
    assign w_wr  = WE && (WADDR != '0);
    assign w_iss = ISSUE && (ISSUE_ADDR != '0);

    // Issue is applied after the writeback clear so a newer producer keeps the bit set.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr)
            w_pend_nxt[WADDR] = 1'b0;
        if (w_iss)
            w_pend_nxt[ISSUE_ADDR] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_pend  <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_W'(NREGS - 1))
                        r_state <= ST_RUN;
                end
                default: begin
                    r_pend <= w_pend_nxt;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!w_run)
            r_mem[r_cnt] <= '0;
        else if (w_wr)
            r_mem[WADDR] <= WDATA;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_live;
        logic              w_byp;

        assign w_ra   = RADDR[k*ADDR_W +: ADDR_W];
        assign w_live = w_run && (w_ra != '0);
        assign w_byp  = WE && (WADDR == w_ra);

        assign RDATA[k*DATA_W +: DATA_W] = !w_live ? '0 :
                                           w_byp   ? WDATA : r_mem[w_ra];
        assign RBUSY[k] = w_live && r_pend[w_ra] && !w_byp;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port integer register file for the RISC-V pipeline, replacing the fixed 32x32, two-read-port register file. It adds hardwired-zero register 0 and same-cycle write-to-read bypass. It also keeps a per-register pending scoreboard so the decode stage can detect RAW hazards. After reset, a sequential clear sweep zeroes the array, and READY goes high when the sweep completes.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)

- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- READY  out  1  high once the clear sweep is done and the file accepts writes/issues
- WE  in  1  write enable (writeback stage)
- WADDR  in  ADDR_W  write address
- WDATA  in  DATA_W  write data
- ISSUE  in  1  mark ISSUE_ADDR as pending (instruction with destination issued)
- ISSUE_ADDR  in  ADDR_W  destination register being issued
- RADDR  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- RDATA  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- RBUSY  out  NUM_RD  port k's register has an outstanding producer

## Operation
- Storage: NREGS x DATA_W array, not itself async-reset. Pending vector pend[NREGS-1:0], sweep counter cnt[ADDR_W-1:0] and state are async-reset.
- State machine has two states, CLEAR and RUN.
  - RESET high forces CLEAR, cnt=0, pend=0, READY=0.
  - In CLEAR, each rising edge writes 0 to reg[cnt] and increments cnt. On the edge that writes reg[NREGS-1], the next state is RUN.
  - In RUN, READY=1. RUN stays in RUN until the next RESET.
- During CLEAR: WE and ISSUE are ignored, RDATA=0 on all ports, RBUSY=0.
- Write in RUN: when WE=1 and WADDR!=0, reg[WADDR]<=WDATA and pend[WADDR]<=0 on the rising edge. A write to address 0 is discarded.
- Issue in RUN: when ISSUE=1 and ISSUE_ADDR!=0, pend[ISSUE_ADDR]<=1. An issue to address 0 is discarded.
- Write and issue to the same nonzero address in the same cycle: the issue wins and pend stays 1, because the newer producer is outstanding. Different addresses update independently.
- Read port k is combinational, with this priority:
  - RADDR_k==0 gives RDATA_k=0.
  - Otherwise, RUN, WE=1 and WADDR==RADDR_k gives RDATA_k=WDATA (bypass).
  - Otherwise RDATA_k=reg[RADDR_k].
- RBUSY_k = pend[RADDR_k] & ~(WE & WADDR==RADDR_k), forced 0 when RADDR_k==0 or in CLEAR. A same-cycle ISSUE does not affect RBUSY until the next cycle.
- All read ports are independent; any ports may alias the same address.

## Timing
- Write latency: 1 edge to the array. Data is visible on RDATA in the same cycle through the bypass and from the array on following cycles.
- Issue latency: RBUSY rises the cycle after the ISSUE edge.
- Reset: async assertion immediately drives READY=0, RDATA=0 and RBUSY=0. After deassertion, READY rises exactly NREGS rising edges later (32 for the default).
- RESET mid-RUN or mid-CLEAR restarts the sweep from cnt=0 and clears all pend bits. Prior register contents are overwritten by the sweep.
- cnt wrap: cnt reaches NREGS-1 and the state leaves CLEAR. cnt is not used in RUN.
- No zero-delay or # delays in RTL. Reads are purely combinational from the current state plus the write port.

## Test plan
- Reset sweep: pulse RESET, then release → READY=0 for 32 edges and 1 on the 32nd. Reading any address, e.g. 7, gives RDATA=0 and RBUSY=0. WE=1 to x5 during CLEAR is ignored, so x5 reads 0 afterwards.
- Write/read and bypass: in RUN, WE=1, WADDR=3, WDATA=0xDEADBEEF with RADDR0=3 in the same cycle → RDATA0=0xDEADBEEF combinationally. The next cycle with WE=0 also reads 0xDEADBEEF. A write to x0 of 0x1234 → x0 still reads 0.
- Scoreboard: ISSUE to x10 → RBUSY for RADDR=10 is 1 from the next cycle. A writeback WE to x10 with 0x55 → RBUSY=0 in the same cycle (bypass) and pend cleared after the edge.
- Simultaneous issue and write: ISSUE_ADDR=12 and WADDR=12 in the same cycle → x12 holds the new data and RBUSY for x12 is 1 the next cycle. ISSUE to x0 → RBUSY on x0 stays 0.
- Multi-port aliasing with NUM_RD=3: all ports on x4=0xA5A5A5A5 return identical data, and ports on x0 return 0.
- Reset mid-operation: with pend set on x10 and x4 holding 0xA5A5A5A5, assert RESET async → READY and RBUSY drop immediately. After the sweep, x4=0 and no pend bit is set.
